// File: rtl/baseline_pkg.sv
// Shared types and defaults for the baseline restore stream path.
package baseline_pkg;

    localparam int W_DEF        = 14;
    localparam int MAX_STEP_DEF = 16;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Increment v by one, holding at max_v once reached.
    function automatic int unsigned sat_add(input int unsigned v, input int unsigned max_v);
        return (v >= max_v) ? max_v : v + 1;
    endfunction

endpackage

// File: rtl/baseline_skid_fifo.sv
// Two-entry in-order valid/ready buffer. Head entry drives the output
// directly, so a pushed word is visible the cycle after the push edge.
module baseline_skid_fifo #(
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] push_data_i,
    input  logic          push_i,
    output logic [DW-1:0] pop_data_o,
    output logic          pop_vld_o,
    input  logic          pop_rdy_i,
    output logic          full_o,
    output logic          drop_o
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q,  cnt_d;
    logic          pop;

    assign pop_vld_o  = (cnt_q != 2'd0);
    assign full_o     = (cnt_q == 2'd2);
    assign pop        = pop_vld_o & pop_rdy_i;
    assign pop_data_o = head_q;
    // A push only gets lost when both slots are taken and nothing leaves.
    assign drop_o     = push_i & full_o & ~pop_rdy_i;

    // Next-state for the two slots and the occupancy count.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({push_i, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data_i;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_d = push_data_i;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the pushed word takes the last slot.
                if (cnt_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // Slot and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two data slots are reset too, because out_data must read 0 while in reset; a larger RAM would not be.
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/baseline_restore.sv
// Re-adds a slew-limited copy of the remover's baseline to the residual
// stream, clamps to the sample range and buffers the result.
module baseline_restore
    import baseline_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MAX_STEP = MAX_STEP_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] resid,
    input  logic                samp_vld,
    input  logic signed [W-1:0] base_in,
    input  logic                base_vld,
    input  logic                start_in,
    output logic signed [W-1:0] out_data,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                locked,
    output logic [CNT_W-1:0]    sat_cnt,
    output logic [CNT_W-1:0]    ovf_cnt
);

    localparam logic signed [W:0]   STEP_POS = (W+1)'(MAX_STEP);
    localparam logic signed [W:0]   STEP_NEG = -STEP_POS;
    localparam logic signed [W-1:0] STEP_W   = W'(MAX_STEP);
    localparam logic [W-1:0]        S_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]        S_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam int unsigned         CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

    state_e              state_q, state_d;
    logic                slew_en;
    logic                locked_q;
    logic signed [W-1:0] base_hold_q, base_hold_d;
    logic signed [W:0]   diff;
    logic [W:0]          sum;
    logic                clip;
    logic [W-1:0]        recon;
    logic [CNT_W-1:0]    sat_cnt_q, sat_cnt_d;
    logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic [W-1:0]        fifo_data;
    logic                fifo_full;
    logic                fifo_drop;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock sequencing: wake on first sample, run once the remover window is full.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (samp_vld)  state_d = PRIME;
            PRIME:   if (!start_in) state_d = RUN;
            RUN:     if (start_in)  state_d = PRIME;
            default:                state_d = IDLE;
        endcase
    end

    // State-derived controls: the slew limit only applies once running.
    always_comb begin
        slew_en = (state_q == RUN);
    end

    // Baseline hold: follow directly until locked, then move at most MAX_STEP per update.
    always_comb begin
        diff        = {base_in[W-1], base_in} - {base_hold_q[W-1], base_hold_q};
        base_hold_d = base_hold_q;
        if (base_vld) begin
            if (!slew_en) begin
                base_hold_d = base_in;
            end else if (diff > STEP_POS) begin
                base_hold_d = base_hold_q + STEP_W;
            end else if (diff < STEP_NEG) begin
                base_hold_d = base_hold_q - STEP_W;
            end else begin
                base_hold_d = base_in;
            end
        end
    end

    // Reconstruction with the pre-update baseline, clamped to the sample range.
    always_comb begin
        sum   = {resid[W-1], resid} + {base_hold_q[W-1], base_hold_q};
        clip  = sum[W] ^ sum[W-1];
        recon = sum[W-1:0];
        if (clip) begin
            recon = sum[W] ? S_MIN : S_MAX;
        end
    end

    // Saturating status counters; they clear only on reset.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (samp_vld && clip) begin
            sat_cnt_d = CNT_W'(sat_add(32'(sat_cnt_q), CNT_MAX));
        end
        if (fifo_drop) begin
            ovf_cnt_d = CNT_W'(sat_add(32'(ovf_cnt_q), CNT_MAX));
        end
    end

    // Baseline hold, registered lock flag and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_hold_q <= '0;
            locked_q    <= 1'b0;
            sat_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            base_hold_q <= base_hold_d;
            locked_q    <= slew_en;
            sat_cnt_q   <= sat_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // Every valid sample is produced: the one arriving in IDLE is the one that leaves it.
    baseline_skid_fifo #(
        .DW (W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_data_i (recon),
        .push_i      (samp_vld),
        .pop_data_o  (fifo_data),
        .pop_vld_o   (out_vld),
        .pop_rdy_i   (out_rdy),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop)
    );

    assign out_data = fifo_data;
    assign locked   = locked_q;
    assign sat_cnt  = sat_cnt_q;
    assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_baseline_restore.sv
// Directed bench for baseline_restore: a vector table for the lock, slew and
// clamp behaviour, then hand sequences for buffering, reset and saturation.
module tb_baseline_restore;

    localparam int W     = 14;
    localparam int CNT_W = 8;
    localparam int NV    = 25;

    typedef struct {
        logic signed [W-1:0] resid;
        logic                samp;
        logic signed [W-1:0] base;
        logic                bvld;
        logic                start;
        logic                rdy;
        logic signed [W-1:0] e_data;
        logic                e_vld;
        logic                e_lock;
        logic [CNT_W-1:0]    e_sat;
        logic [CNT_W-1:0]    e_ovf;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] resid;
    logic                samp_vld;
    logic signed [W-1:0] base_in;
    logic                base_vld;
    logic                start_in;
    logic signed [W-1:0] out_data;
    logic                out_vld;
    logic                out_rdy;
    logic                locked;
    logic [CNT_W-1:0]    sat_cnt;
    logic [CNT_W-1:0]    ovf_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vec [NV];

    always #5 clk = ~clk;

    baseline_restore dut (
        .clk      (clk),
        .rst      (rst),
        .resid    (resid),
        .samp_vld (samp_vld),
        .base_in  (base_in),
        .base_vld (base_vld),
        .start_in (start_in),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .locked   (locked),
        .sat_cnt  (sat_cnt),
        .ovf_cnt  (ovf_cnt)
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input int s, input int b, input int bv, input int st, input int rd);
        resid    = W'(r);
        samp_vld = (s != 0);
        base_in  = W'(b);
        base_vld = (bv != 0);
        start_in = (st != 0);
        out_rdy  = (rd != 0);
    endtask

    // Inputs set before the edge; outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int r, input int s, input int b, input int bv, input int st,
                                input int d, input int v, input int lk, input int sc, input int oc);
        vec_t t;
        t.resid  = W'(r);
        t.samp   = (s != 0);
        t.base   = W'(b);
        t.bvld   = (bv != 0);
        t.start  = (st != 0);
        t.rdy    = 1'b1;
        t.e_data = W'(d);
        t.e_vld  = (v != 0);
        t.e_lock = (lk != 0);
        t.e_sat  = CNT_W'(sc);
        t.e_ovf  = CNT_W'(oc);
        return t;
    endfunction

    initial begin
        //            resid  s  base  bv st | data  vld lk sat ovf
        vec[0]  = mk(    0, 0,  100, 1, 1,      0, 0, 0, 0, 0); // IDLE: hold follows directly
        vec[1]  = mk(    5, 1,    0, 0, 1,    105, 1, 0, 0, 0); // first sample produced
        vec[2]  = mk(    0, 0,    0, 0, 0,      0, 0, 0, 0, 0); // PRIME -> RUN
        vec[3]  = mk(    0, 0,    0, 0, 0,      0, 0, 1, 0, 0); // locked one cycle later
        vec[4]  = mk(    0, 0,  200, 1, 0,      0, 0, 1, 0, 0); // hold 116
        vec[5]  = mk(    0, 1,  200, 1, 0,    116, 1, 1, 0, 0); // coincident: old hold
        vec[6]  = mk(    0, 1,  200, 1, 0,    132, 1, 1, 0, 0);
        vec[7]  = mk(    0, 1,  200, 1, 0,    148, 1, 1, 0, 0);
        vec[8]  = mk(    0, 1,  200, 1, 0,    164, 1, 1, 0, 0);
        vec[9]  = mk(    0, 1,  185, 1, 0,    180, 1, 1, 0, 0); // hold -> 185 exactly
        vec[10] = mk(    0, 1,    0, 0, 0,    185, 1, 1, 0, 0);
        vec[11] = mk(    0, 1,  100, 1, 0,    185, 1, 1, 0, 0); // downward step: 169
        vec[12] = mk(    0, 1,    0, 0, 0,    169, 1, 1, 0, 0);
        vec[13] = mk(    0, 1,  185, 1, 0,    169, 1, 1, 0, 0); // d == +16: taken directly
        vec[14] = mk(    3, 1,    0, 0, 0,    188, 1, 1, 0, 0);
        vec[15] = mk( -200, 1,    0, 0, 0,    -15, 1, 1, 0, 0);
        vec[16] = mk(    0, 0,    0, 0, 1,      0, 0, 1, 0, 0); // start_in high: back to PRIME
        vec[17] = mk(    0, 0, 8000, 1, 1,      0, 0, 0, 0, 0); // locked drops, bypass load
        vec[18] = mk(  500, 1,    0, 0, 1,   8191, 1, 0, 1, 0); // clamp high
        vec[19] = mk(    0, 0,-8000, 1, 1,      0, 0, 0, 1, 0);
        vec[20] = mk( -500, 1,    0, 0, 1,  -8192, 1, 0, 2, 0); // clamp low
        vec[21] = mk( -192, 1, 8000, 1, 1,  -8192, 1, 0, 2, 0); // exact minimum, no clamp
        vec[22] = mk(  191, 1,    0, 0, 1,   8191, 1, 0, 2, 0); // exact maximum, no clamp
        vec[23] = mk(  192, 1,    0, 0, 1,   8191, 1, 0, 3, 0); // one over: clamp
        vec[24] = mk(    0, 0,    0, 1, 1,      0, 0, 0, 3, 0); // hold back to 0

        // Reset state.
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        check("rst out_vld", out_vld, 0);
        check("rst out_data", out_data, 0);
        check("rst locked", locked, 0);
        check("rst sat_cnt", sat_cnt, 0);
        check("rst ovf_cnt", ovf_cnt, 0);
        #3 rst = 1'b1;

        // Table-driven lock, slew and clamp vectors.
        for (int i = 0; i < NV; i++) begin
            resid    = vec[i].resid;
            samp_vld = vec[i].samp;
            base_in  = vec[i].base;
            base_vld = vec[i].bvld;
            start_in = vec[i].start;
            out_rdy  = vec[i].rdy;
            tick();
            if (vec[i].e_vld) check($sformatf("v%0d out_data", i), out_data, vec[i].e_data);
            check($sformatf("v%0d out_vld", i), out_vld, vec[i].e_vld);
            check($sformatf("v%0d locked", i), locked, vec[i].e_lock);
            check($sformatf("v%0d sat_cnt", i), sat_cnt, vec[i].e_sat);
            check($sformatf("v%0d ovf_cnt", i), ovf_cnt, vec[i].e_ovf);
        end

        // Backpressure: third sample overflows, head held stable.
        drive(1, 1, 0, 0, 1, 0); tick();
        check("bp1 data", out_data, 1);
        check("bp1 vld", out_vld, 1);
        drive(2, 1, 0, 0, 1, 0); tick();
        check("bp2 data", out_data, 1);
        check("bp2 ovf", ovf_cnt, 0);
        drive(3, 1, 0, 0, 1, 0); tick();
        check("bp3 data", out_data, 1);
        check("bp3 ovf", ovf_cnt, 1);
        drive(0, 0, 0, 0, 1, 0); tick();
        check("bp hold data", out_data, 1);
        check("bp hold vld", out_vld, 1);
        drive(0, 0, 0, 0, 1, 1); tick();
        check("bp drain data", out_data, 2);
        check("bp drain vld", out_vld, 1);
        tick();
        check("bp empty vld", out_vld, 0);
        check("bp sat", sat_cnt, 3);

        // Full buffer with simultaneous push and pop: nothing dropped.
        drive(10, 1, 0, 0, 1, 0); tick();
        drive(11, 1, 0, 0, 1, 0); tick();
        check("full head", out_data, 10);
        drive(12, 1, 0, 0, 1, 1); tick();
        check("pp data", out_data, 11);
        check("pp ovf", ovf_cnt, 1);
        drive(0, 0, 0, 0, 1, 1); tick();
        check("pp next data", out_data, 12);
        check("pp next vld", out_vld, 1);
        tick();
        check("pp empty vld", out_vld, 0);

        // Asynchronous reset mid-stream.
        drive(7, 1, 0, 0, 1, 0); tick();
        check("pre-rst data", out_data, 7);
        check("pre-rst vld", out_vld, 1);
        #2 rst = 1'b0;
        #1;
        check("async vld", out_vld, 0);
        check("async data", out_data, 0);
        check("async sat", sat_cnt, 0);
        check("async ovf", ovf_cnt, 0);
        check("async locked", locked, 0);
        drive(0, 0, 0, 0, 1, 0);
        tick();
        #2 rst = 1'b1;

        // Counter saturation: 260 clamped samples into a blocked buffer.
        drive(0, 0, 8000, 1, 1, 0); tick();
        check("sat pre", sat_cnt, 0);
        drive(500, 1, 0, 0, 1, 0);
        repeat (260) tick();
        check("sat cap", sat_cnt, 255);
        check("ovf cap", ovf_cnt, 255);
        check("sat head", out_data, 8191);
        check("sat vld", out_vld, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
